// File: rtl/uart_frame_tx.sv
// UART transmit framer: pops one FIFO word and writes SOF, payload bytes and an
// optional checksum (enabled with `UART_FRAME_CHECKSUM_EN) to the UART core.
module uart_frame_tx #(
  parameter int         FRAME_BYTES  = 5,
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter bit         MSB_FIRST    = 1'b1,
  parameter int         READ_LATENCY = 1,
  parameter int         GUARD_CYCLES = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Fifo_Empty,
  input  logic [FRAME_BYTES*8-1:0] Fifo_Read_Data,
  output logic                     Fifo_Read_Enable,
  input  logic                     UART_TX_Ready,
  output logic                     UART_TX_Enable,
  output logic [7:0]               UART_TX_Data,
  output logic                     Busy,
  output logic                     Diag_Valid,
  output logic [15:0]              Frame_Count
);

  // state  | meaning
  // IDLE   | no frame; pop when FIFO not empty
  // POP    | pop strobe cycle; capture here when READ_LATENCY=0
  // WAIT_Q | waiting for FIFO Q; capture on terminal count
  // SEND   | byte pending, waiting for UART_TX_Ready
  // GUARD  | post-write hold-off, UART_TX_Ready ignored

  localparam int W = FRAME_BYTES * 8;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int TAIL = FRAME_BYTES + 1;
`else
  localparam int TAIL = FRAME_BYTES;
`endif
  localparam logic [4:0] TAIL_LOAD  = 5'(TAIL);
  localparam logic [1:0] WAIT_LOAD  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [2:0] GUARD_LOAD = 3'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    WAIT_Q = 3'd2,
    SEND   = 3'd3,
    GUARD  = 3'd4
  } state_t;

  state_t       state;
  logic [W-1:0] shreg;
  logic [7:0]   next_byte;
  logic [4:0]   bytes_left;
  logic [1:0]   wait_cnt;
  logic [2:0]   guard_cnt;
  logic         last_write;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]   sum_acc;
  logic [7:0]   sum_base;
`endif

  logic         capture;
  logic         emit;
  logic [W-1:0] load_src;
  logic [4:0]   emit_left;
  logic [7:0]   emit_byte;

  function automatic logic [7:0] head_byte(input logic [W-1:0] v);
    if (MSB_FIRST) return v[W-1 -: 8];
    else           return v[7:0];
  endfunction

  function automatic logic [W-1:0] shift_out(input logic [W-1:0] v);
    if (MSB_FIRST) return v << 8;
    else           return v >> 8;
  endfunction

  // On capture the SOF goes out straight away if the UART is ready, so the
  // write path sees either the fresh FIFO word or the working shift register.
  always_comb begin
    capture = 1'b0;
    if (state == POP && READ_LATENCY == 0) capture = 1'b1;
    if (state == WAIT_Q && wait_cnt == 2'd0) capture = 1'b1;
    emit      = (capture || state == SEND) && UART_TX_Ready;
    load_src  = capture ? Fifo_Read_Data : shreg;
    emit_left = capture ? TAIL_LOAD : bytes_left;
    emit_byte = capture ? SOF_BYTE : next_byte;
`ifdef UART_FRAME_CHECKSUM_EN
    sum_base  = capture ? 8'd0 : sum_acc;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= IDLE;
      shreg            <= '0;
      next_byte        <= 8'd0;
      bytes_left       <= 5'd0;
      wait_cnt         <= 2'd0;
      guard_cnt        <= 3'd0;
      last_write       <= 1'b0;
      Fifo_Read_Enable <= 1'b0;
      UART_TX_Enable   <= 1'b0;
      UART_TX_Data     <= 8'd0;
      Busy             <= 1'b0;
      Diag_Valid       <= 1'b0;
      Frame_Count      <= 16'd0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_acc          <= 8'd0;
`endif
    end else begin
      Fifo_Read_Enable <= 1'b0;
      UART_TX_Enable   <= 1'b0;
      Diag_Valid       <= 1'b0;

      case (state)
        IDLE: begin
          if (!Fifo_Empty) begin
            Fifo_Read_Enable <= 1'b1;
            Busy             <= 1'b1;
            state            <= POP;
          end
        end
        POP: begin
          if (READ_LATENCY != 0) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT_Q;
          end
        end
        WAIT_Q: begin
          if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
        end
        SEND: ;
        GUARD: begin
          if (guard_cnt != 3'd0) begin
            guard_cnt <= guard_cnt - 3'd1;
          end else if (last_write) begin
            last_write  <= 1'b0;
            Busy        <= 1'b0;
            Diag_Valid  <= 1'b1;
            Frame_Count <= Frame_Count + 16'd1;
            state       <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture && !UART_TX_Ready) begin
        shreg      <= Fifo_Read_Data;
        next_byte  <= SOF_BYTE;
        bytes_left <= TAIL_LOAD;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_acc    <= 8'd0;
`endif
        state      <= SEND;
      end

      if (emit) begin
        UART_TX_Enable <= 1'b1;
        UART_TX_Data   <= emit_byte;
        guard_cnt      <= GUARD_LOAD;
        state          <= GUARD;
        if (emit_left == 5'd0) begin
          last_write <= 1'b1;
        end else begin
          bytes_left <= emit_left - 5'd1;
`ifdef UART_FRAME_CHECKSUM_EN
          if (emit_left == 5'd1) begin
            next_byte <= (~sum_base) + 8'd1;
          end else begin
            next_byte <= head_byte(load_src);
            shreg     <= shift_out(load_src);
            sum_acc   <= sum_base + head_byte(load_src);
          end
`else
          next_byte <= head_byte(load_src);
          shreg     <= shift_out(load_src);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: two instances (MSB-first and LSB-first)
// share one FIFO model and one UART ready line.
module tb_uart_frame_tx;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [39:0] fifo_rdata;
  logic        ready;

  logic        rd_m, en_m, busy_m, diag_m;
  logic [7:0]  data_m;
  logic [15:0] cnt_m;
  logic        rd_l, en_l, busy_l, diag_l;
  logic [7:0]  data_l;
  logic [15:0] cnt_l;

  always #5 clk = ~clk;

  uart_frame_tx #(.FRAME_BYTES(5), .SOF_BYTE(8'hA5), .MSB_FIRST(1'b1),
                  .READ_LATENCY(1), .GUARD_CYCLES(2)) u_msb (
    .Clock(clk), .Reset(rst), .Fifo_Empty(fifo_empty), .Fifo_Read_Data(fifo_rdata),
    .Fifo_Read_Enable(rd_m), .UART_TX_Ready(ready), .UART_TX_Enable(en_m),
    .UART_TX_Data(data_m), .Busy(busy_m), .Diag_Valid(diag_m), .Frame_Count(cnt_m));

  uart_frame_tx #(.FRAME_BYTES(5), .SOF_BYTE(8'hA5), .MSB_FIRST(1'b0),
                  .READ_LATENCY(1), .GUARD_CYCLES(2)) u_lsb (
    .Clock(clk), .Reset(rst), .Fifo_Empty(fifo_empty), .Fifo_Read_Data(fifo_rdata),
    .Fifo_Read_Enable(rd_l), .UART_TX_Ready(ready), .UART_TX_Enable(en_l),
    .UART_TX_Data(data_l), .Busy(busy_l), .Diag_Valid(diag_l), .Frame_Count(cnt_l));

  int checks = 0;
  int errors = 0;

  logic [39:0] fifo_q[$];
  logic [7:0]  wr_m[$];
  logic [7:0]  wr_l[$];
  int cyc, diag_cnt, diag_l_cnt, pops, overlap_err, underflow_err, pop_age;
  int pop_cyc, first_en_cyc;
  bit frame_open;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe both DUTs at the falling edge and service the FIFO model
  // (Q valid one cycle after the pop, scrambled afterwards).
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (en_m) begin
      if (first_en_cyc < 0) first_en_cyc = cyc;
      wr_m.push_back(data_m);
    end
    if (en_l) wr_l.push_back(data_l);
    if (rd_m) begin
      pops++;
      pop_cyc = cyc;
      if (frame_open) overlap_err++;
      frame_open = 1'b1;
      pop_age = 0;
      if (fifo_q.size() == 0) underflow_err++;
      else fifo_rdata = fifo_q.pop_front();
    end else begin
      pop_age++;
      if (pop_age >= 2) fifo_rdata = {8'h5A, 32'($urandom())};
    end
    if (diag_m) begin
      diag_cnt++;
      frame_open = 1'b0;
    end
    if (diag_l) diag_l_cnt++;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [39:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_rec();
    wr_m.delete();
    wr_l.delete();
    diag_cnt = 0;
    diag_l_cnt = 0;
    pops = 0;
    first_en_cyc = -1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    frame_open = 1'b0;
  endtask

  task automatic run_until_diag(input int target, input int budget);
    int b = 0;
    while (diag_cnt < target && b < budget) begin
      tick();
      b++;
    end
    if (diag_cnt < target) check("timeout_diag", 64'(diag_cnt), 64'(target));
  endtask

  task automatic wait_writes(input int n, input int budget);
    int b = 0;
    while (wr_m.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (wr_m.size() < n) check("timeout_writes", 64'(wr_m.size()), 64'(n));
  endtask

  function automatic logic [63:0] pack_wr(input bit lsb, input int s, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (lsb && s + i < wr_l.size()) v = (v << 8) | 64'(wr_l[s + i]);
      else if (!lsb && s + i < wr_m.size()) v = (v << 8) | 64'(wr_m[s + i]);
      else v = (v << 8) | 64'hEE;
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_frame(input logic [39:0] w, input bit msb);
    logic [63:0] v = 64'hA5;
    logic [7:0]  sum = 8'd0;
    logic [7:0]  b;
    for (int i = 0; i < 5; i++) begin
      b = msb ? w[39 - 8*i -: 8] : w[8*i +: 8];
      v = (v << 8) | 64'(b);
      sum = sum + b;
    end
`ifdef UART_FRAME_CHECKSUM_EN
    v = (v << 8) | 64'(8'(~sum + 8'd1));
`endif
    return v;
  endfunction

  logic [39:0] words[3];
  logic [63:0] exp_t1_m, exp_t1_l;
  int n_en, data_chg;

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    cyc = 0;
    overlap_err = 0;
    underflow_err = 0;
    pop_age = 10;
    pop_cyc = 0;
    frame_open = 1'b0;
    clear_rec();

    repeat (3) tick();
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_tx_en", 64'(en_m), 64'd0);
    check("rst_rd_en", 64'(rd_m), 64'd0);
    check("rst_diag", 64'(diag_m), 64'd0);
    check("rst_data", 64'(data_m), 64'd0);
    check("rst_count", 64'(cnt_m), 64'd0);
    rst = 1'b0;
    tick();
    clear_rec();

    // Basic frame, both byte orders
`ifdef UART_FRAME_CHECKSUM_EN
    exp_t1_m = 64'hA50102030405F1;
    exp_t1_l = 64'hA50504030201F1;
`else
    exp_t1_m = 64'hA50102030405;
    exp_t1_l = 64'hA50504030201;
`endif
    push(40'h0102030405);
    run_until_diag(1, 100);
    repeat (3) tick();
    check("t1_writes", 64'(wr_m.size()), 64'(NB));
    check("t1_msb_bytes", pack_wr(1'b0, 0, NB), exp_t1_m);
    check("t1_lsb_writes", 64'(wr_l.size()), 64'(NB));
    check("t1_lsb_bytes", pack_wr(1'b1, 0, NB), exp_t1_l);
    check("t1_diag", 64'(diag_cnt), 64'd1);
    check("t1_diag_lsb", 64'(diag_l_cnt), 64'd1);
    check("t1_count", 64'(cnt_m), 64'd1);
    check("t1_latency", 64'(first_en_cyc - pop_cyc), 64'd2);
    check("t1_idle", 64'(busy_m), 64'd0);

    // Back-pressure after payload byte 2, then a ready pulse inside the guard window
    clear_rec();
    push(40'h1122334455);
    wait_writes(3, 100);
    ready = 1'b0;
    n_en = 0;
    data_chg = 0;
    repeat (50) begin
      tick();
      if (en_m) n_en++;
      if (data_m !== 8'h22) data_chg++;
    end
    check("stall_writes", 64'(n_en), 64'd0);
    check("stall_data_changes", 64'(data_chg), 64'd0);
    ready = 1'b1;
    tick();
    check("release_en", 64'(en_m), 64'd1);
    check("release_data", 64'(data_m), 64'h33);
    n_en = 0;
    tick();
    if (en_m) n_en++;
    ready = 1'b0;
    repeat (10) begin
      tick();
      if (en_m) n_en++;
    end
    check("guard_pulse_writes", 64'(n_en), 64'd0);
    ready = 1'b1;
    run_until_diag(1, 100);
    repeat (3) tick();
    check("t4_writes", 64'(wr_m.size()), 64'(NB));
    check("t4_bytes", pack_wr(1'b0, 0, NB), exp_frame(40'h1122334455, 1'b1));
    check("t4_count", 64'(cnt_m), 64'd2);

    // Three queued frames from a fresh reset
    do_reset(2);
    clear_rec();
    words[0] = 40'hA1A2A3A4A5;
    words[1] = 40'hB1B2B3B4B5;
    words[2] = 40'hC1C2C3C4C5;
    for (int i = 0; i < 3; i++) push(words[i]);
    run_until_diag(3, 300);
    repeat (3) tick();
    check("t5_pops", 64'(pops), 64'd3);
    check("t5_count", 64'(cnt_m), 64'd3);
    check("t5_writes", 64'(wr_m.size()), 64'(3 * NB));
    for (int f = 0; f < 3; f++)
      check($sformatf("t5_frame%0d", f), pack_wr(1'b0, f * NB, NB), exp_frame(words[f], 1'b1));
    check("t5_lsb_frame2", pack_wr(1'b1, 2 * NB, NB), exp_frame(words[2], 1'b0));

    // Reset while payload byte 3 is on the wire
    clear_rec();
    push(40'h0102030405);
    wait_writes(4, 100);
    rst = 1'b1;
    tick();
    check("t6_busy", 64'(busy_m), 64'd0);
    check("t6_tx_en", 64'(en_m), 64'd0);
    check("t6_rd_en", 64'(rd_m), 64'd0);
    check("t6_data", 64'(data_m), 64'd0);
    check("t6_count", 64'(cnt_m), 64'd0);
    rst = 1'b0;
    frame_open = 1'b0;
    clear_rec();
    repeat (5) tick();
    check("t6_no_resend", 64'(wr_m.size()), 64'd0);
    push(40'h6162636465);
    run_until_diag(1, 100);
    repeat (3) tick();
    check("t6_pops", 64'(pops), 64'd1);
    check("t6_bytes", pack_wr(1'b0, 0, NB), exp_frame(40'h6162636465, 1'b1));
    check("t6_count", 64'(cnt_m), 64'd1);

    check("pop_overlap", 64'(overlap_err), 64'd0);
    check("pop_underflow", 64'(underflow_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
